// File: rtl/regfile_pkg.sv
// Shared constants, command encodings and FSM state type for the
// register-file loader.
package regfile_pkg;

  localparam int NUM_REGS = 12;
  localparam int AW       = 4;
  localparam int DW       = 8;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_BWR = 2'd2;
  localparam logic [1:0] OP_BRD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_WAIT  = 3'd1,
    ST_WR_DRIVE = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_CAPT  = 3'd4,
    ST_RD_OUT   = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_bus_if.sv
// Bidirectional buffer for the shared register-file data bus: drives only
// while drive_en is high, otherwise releases the bus to the register file.
module regfile_bus_if
  import regfile_pkg::*;
(
  input  logic          drive_en,
  input  logic [DW-1:0] drive_data,
  output logic [DW-1:0] sample_data,
  inout  wire  [DW-1:0] bus
);

  assign bus         = drive_en ? drive_data : {DW{1'bz}};
  assign sample_data = bus;

endmodule

// File: rtl/regfile_loader.sv
// Host-side sequencer turning single/burst read/write commands into
// register-file bus cycles, with read data returned on a streaming port.
module regfile_loader
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] rf_address,
  output logic          rf_en_write,
  inout  wire  [DW-1:0] rf_data,
  output logic          busy,
  output logic          err
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, and the producer holds its
  // payload stable until the transfer edge.

  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(NUM_REGS);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;
  logic [DW-1:0] drive_data;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] len_eff;
  logic [AW:0]   end_addr;
  logic          range_bad;
  logic          last;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign last      = (remaining == '0);
  assign wr_ready  = (state == ST_WR_WAIT) || ((state == ST_WR_DRIVE) && !last);

  // One extra bit on the end address catches carry-out as out of range.
  assign len_eff   = cmd_op[1] ? cmd_len : '0;
  assign end_addr  = {1'b0, cmd_addr} + {1'b0, len_eff};
  assign range_bad = (end_addr >= ADDR_LIMIT);

  regfile_bus_if u_bus_if (
    .drive_en    (rf_en_write),
    .drive_data  (drive_data),
    .sample_data (sample_data),
    .bus         (rf_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      rf_address  <= '0;
      rf_en_write <= 1'b0;
      drive_data  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_addr     <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (range_bad) begin
              err <= 1'b1;
            end else begin
              addr      <= cmd_addr;
              remaining <= len_eff;
              if (cmd_op[0]) begin
                rf_address <= cmd_addr;
                state      <= ST_RD_ISSUE;
              end else begin
                state <= ST_WR_WAIT;
              end
            end
          end
        end
        ST_WR_WAIT: begin
          if (wr_valid) begin
            rf_address  <= addr;
            drive_data  <= wr_data;
            rf_en_write <= 1'b1;
            state       <= ST_WR_DRIVE;
          end
        end
        ST_WR_DRIVE: begin
          if (last) begin
            rf_en_write <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            // A byte already waiting keeps the bus in write mode back to back.
            if (wr_valid) begin
              rf_address <= addr + 1'b1;
              drive_data <= wr_data;
            end else begin
              rf_en_write <= 1'b0;
              state       <= ST_WR_WAIT;
            end
          end
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          rd_data  <= sample_data;
          rd_addr  <= addr;
          rd_valid <= 1'b1;
          state    <= ST_RD_OUT;
        end
        ST_RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (last) begin
              state <= ST_IDLE;
            end else begin
              addr       <= addr + 1'b1;
              remaining  <= remaining - 1'b1;
              rf_address <= addr + 1'b1;
              state      <= ST_RD_ISSUE;
            end
          end
        end
        default: begin
          rf_en_write <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
Host-side sequencer directly upstream of the 12x8 register file (4-bit address, en_write, shared bidirectional 8-bit data bus). It takes single or burst read/write commands over valid/ready handshakes and converts them into register-file bus cycles. It owns bus-direction control so the loader and the register file never drive the shared bus in the same cycle. Read data is returned on a separate streaming output.

Parameters:
NUM_REGS, 12, number of valid register addresses (0..NUM_REGS-1)
AW, 4, register-file address width
DW, 8, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0 = single write, 1 = single read, 2 = burst write, 3 = burst read
cmd_addr  in  AW  start address
cmd_len  in  AW  burst length minus 1; ignored for single ops
wr_valid  in  1  write-data valid
wr_ready  out  1  write data consumed when valid&ready
wr_data  in  DW  write byte
rd_valid  out  1  read data valid
rd_ready  in  1  read-data sink ready
rd_data  out  DW  read byte
rd_addr  out  AW  address rd_data came from
rf_address  out  AW  register-file address
rf_en_write  out  1  register-file write enable
rf_data  inout  DW  shared bus; driven only while rf_en_write=1, otherwise Z
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset values: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, rd_addr=0, rf_address=0, rf_en_write=0, rf_data=Z, busy=0, err=0. FSM goes to IDLE; any burst in flight is abandoned.
- rf_address, rf_en_write and the drive-data register are flops. The tri-state enable is exactly rf_en_write, so drive and enable switch on the same edge.
- FSM states: IDLE, WR_WAIT, WR_DRIVE, RD_ISSUE, RD_CAPT, RD_OUT.
- IDLE: cmd_ready=1.
  - On accept, compute end = cmd_addr + len (len = 0 for single ops).
  - If end >= NUM_REGS, or the add carries out of AW bits: pulse err, stay in IDLE. Addresses never wrap.
  - Otherwise latch addr and remaining = len, then go to WR_WAIT (ops 0/2) or RD_ISSUE (ops 1/3).
  - cmd_ready=0 in every state except IDLE.
- WR_WAIT: wr_ready=1. On wr_valid, load rf_address=addr, drive data=wr_data, rf_en_write=1; go to WR_DRIVE.
- WR_DRIVE: lasts one cycle; the register file writes on the closing edge.
  - If remaining = 0: rf_en_write<=0, go to IDLE.
  - Else: addr+1, remaining-1. If wr_valid is already high, stay in WR_DRIVE and present the next byte (back-to-back, 1 byte/cycle); otherwise rf_en_write<=0 and go to WR_WAIT.
  - wr_ready=1 in WR_DRIVE only when remaining != 0.
- RD_ISSUE: rf_en_write=0, rf_address=addr for one cycle. The register file latches out_val on that edge.
- RD_CAPT: sample rf_data into rd_data and addr into rd_addr, set rd_valid=1, go to RD_OUT. Read latency from the issued address to captured data is 2 cycles.
- RD_OUT: hold rd_data/rd_addr until rd_ready.
  - On handshake: rd_valid<=0. If remaining = 0, go to IDLE; else addr+1, remaining-1, go to RD_ISSUE.
  - Reads are not pipelined; a burst read takes 3 cycles per byte minimum.
- Bus ownership: the loader drives rf_data only in write cycles; rf_en_write=0 in every other state, which hands the bus to the register file.
- wr_valid outside a write op is ignored (wr_ready=0). rd_ready outside RD_OUT is ignored.
- Reset asserted mid-burst: rf_en_write drops asynchronously and the bus goes Z immediately. A partially written burst leaves earlier registers updated.

Decomposition:
- Shared package regfile_pkg holds:
  - op encodings OP_WR, OP_RD, OP_BWR, OP_BRD
  - NUM_REGS=12, AW=4, DW=8
  - the FSM state enum
- One sub-module is natural: regfile_bus_if (bidirectional buffer), with drive enable, drive data and sampled data, instantiated once. The register file itself is instantiated only in the testbench.

Test Plan:
- Single write op=0 addr=5 data=0xA7, then single read addr=5 -> rd_data=0xA7, rd_addr=5. rd_valid rises 2 cycles after RD_ISSUE. err never pulses.
- Burst write addr=0 len=11 with wr_valid held high over 12 bytes 0x10..0x1B -> rf_en_write high for 12 consecutive cycles. Burst read addr=0 len=11 returns 0x10..0x1B in order.
- Out-of-range commands: addr=10 len=2, addr=12 single, addr=15 len=15 -> each gives a 1-cycle err pulse, no rf_en_write, busy stays 0.
- Burst read addr=3 len=2 with rd_ready held low 5 cycles per byte -> rd_data and rd_addr stable while stalled, exactly 3 beats delivered (addr 3, 4, 5).
- Bus-contention check across all tests: assert rf_data is never X and the loader drive is active only when rf_en_write=1.
- rst_n pulsed low mid burst-write after 4 bytes -> rf_en_write=0 and rf_data=Z asynchronously, all outputs at reset values, regs 0..3 updated, next command accepted normally.
